axi_lite_master: RTL and testbench

//  Command-to-AXI4-Lite bridge that sits directly upstream of the AXI-Lite slave.

---
 rtl/axi_lite_pkg.sv | 33 +++
 rtl/axi_lite_if.sv | 48 ++++
 rtl/axi_lite_master.sv | 130 +++++++++++++
 tb/tb_axi_lite_master.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types for the command bridge and its bus interface.
// Widths, response codes, command bundle and master FSM encoding.
package axi_lite_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned BUFFER_SIZE = 16;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [STRB_W-1:0] strb_t;
    typedef logic [1:0]        resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic  write;
        data_t wdata;
    } cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AW   = 3'd3,
        ST_W    = 3'd4,
        ST_B    = 3'd5,
        ST_RSP  = 3'd6
    } master_state_t;

endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite bus bundle with master and slave views.
// Carries the five channels between the bridge and the slave.
interface axi_lite_if;
    import axi_lite_pkg::*;

    logic  awvalid;
    logic  awready;
    addr_t awaddr;
    logic  wvalid;
    logic  wready;
    data_t wdata;
    strb_t wstrb;
    logic  bvalid;
    logic  bready;
    resp_t bresp;
    logic  arvalid;
    logic  arready;
    addr_t araddr;
    logic  rvalid;
    logic  rready;
    data_t rdata;
    resp_t rresp;

    modport master (
        output awvalid, awaddr,
        output wvalid, wdata, wstrb,
        output bready,
        output arvalid, araddr,
        output rready,
        input  awready, wready,
        input  bvalid, bresp,
        input  arready,
        input  rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr,
        input  wvalid, wdata, wstrb,
        input  bready,
        input  arvalid, araddr,
        input  rready,
        output awready, wready,
        output bvalid, bresp,
        output arready,
        output rvalid, rdata, rresp
    );

endinterface

// File: rtl/axi_lite_master.sv
// Command-to-AXI4-Lite bridge: one command in flight, one held response out.
// Every bus and response output is a flop; nothing is combinational from inputs.
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int unsigned ADDR_LIMIT = BUFFER_SIZE
) (
    input  logic  aclk,
    input  logic  areset_n,
    input  logic  cmd_valid,
    output logic  cmd_ready,
    input  logic  cmd_write,
    input  addr_t cmd_addr,
    input  data_t cmd_wdata,
    output logic  rsp_valid,
    input  logic  rsp_ready,
    output logic  rsp_write,
    output data_t rsp_rdata,
    output resp_t rsp_resp,
    axi_lite_if.master m_axi_lite
);

    master_state_t state;
    cmd_t          cmd_q;

    // Sequencer: accepts a command, walks its AXI handshakes, holds the response.
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state                <= ST_IDLE;
            cmd_q                <= '0;
            cmd_ready            <= 1'b0;
            rsp_valid            <= 1'b0;
            rsp_write            <= 1'b0;
            rsp_rdata            <= '0;
            rsp_resp             <= RESP_OKAY;
            m_axi_lite.arvalid   <= 1'b0;
            m_axi_lite.araddr    <= '0;
            m_axi_lite.rready    <= 1'b0;
            m_axi_lite.awvalid   <= 1'b0;
            m_axi_lite.awaddr    <= '0;
            m_axi_lite.wvalid    <= 1'b0;
            m_axi_lite.wdata     <= '0;
            m_axi_lite.wstrb     <= '0;
            m_axi_lite.bready    <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        cmd_q     <= '{write: cmd_write, wdata: cmd_wdata};
                        if (32'(cmd_addr) >= ADDR_LIMIT) begin
                            state     <= ST_RSP;
                            rsp_valid <= 1'b1;
                            rsp_write <= cmd_write;
                            rsp_rdata <= '0;
                            rsp_resp  <= RESP_SLVERR;
                        end else if (cmd_write) begin
                            state              <= ST_AW;
                            m_axi_lite.awvalid <= 1'b1;
                            m_axi_lite.awaddr  <= cmd_addr;
                        end else begin
                            state              <= ST_AR;
                            m_axi_lite.arvalid <= 1'b1;
                            m_axi_lite.araddr  <= cmd_addr;
                        end
                    end
                end
                ST_AR: begin
                    if (m_axi_lite.arready) begin
                        state              <= ST_R;
                        m_axi_lite.arvalid <= 1'b0;
                        m_axi_lite.araddr  <= '0;
                        m_axi_lite.rready  <= 1'b1;
                    end
                end
                ST_R: begin
                    if (m_axi_lite.rvalid) begin
                        state             <= ST_RSP;
                        m_axi_lite.rready <= 1'b0;
                        rsp_valid         <= 1'b1;
                        rsp_write         <= cmd_q.write;
                        rsp_rdata         <= m_axi_lite.rdata;
                        rsp_resp          <= m_axi_lite.rresp;
                    end
                end
                ST_AW: begin
                    if (m_axi_lite.awready) begin
                        state              <= ST_W;
                        m_axi_lite.awvalid <= 1'b0;
                        m_axi_lite.awaddr  <= '0;
                        m_axi_lite.wvalid  <= 1'b1;
                        m_axi_lite.wdata   <= cmd_q.wdata;
                        m_axi_lite.wstrb   <= '1;
                    end
                end
                ST_W: begin
                    if (m_axi_lite.wready) begin
                        state             <= ST_B;
                        m_axi_lite.wvalid <= 1'b0;
                        m_axi_lite.wdata  <= '0;
                        m_axi_lite.wstrb  <= '0;
                        m_axi_lite.bready <= 1'b1;
                    end
                end
                ST_B: begin
                    if (m_axi_lite.bvalid) begin
                        state             <= ST_RSP;
                        m_axi_lite.bready <= 1'b0;
                        rsp_valid         <= 1'b1;
                        rsp_write         <= cmd_q.write;
                        rsp_rdata         <= '0;
                        rsp_resp          <= m_axi_lite.bresp;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: behavioural slave with random wait states,
// directed scenarios and a random command run checked against a memory model.
module tb_axi_lite_master;
    import axi_lite_pkg::*;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    logic  cmd_valid = 1'b0;
    logic  cmd_ready;
    logic  cmd_write = 1'b0;
    addr_t cmd_addr = '0;
    data_t cmd_wdata = '0;
    logic  rsp_valid;
    logic  rsp_ready = 1'b0;
    logic  rsp_write;
    data_t rsp_rdata;
    resp_t rsp_resp;

    axi_lite_if bus ();

    axi_lite_master #(.ADDR_LIMIT(BUFFER_SIZE)) dut (
        .aclk       (clk),
        .areset_n   (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_write  (rsp_write),
        .rsp_rdata  (rsp_rdata),
        .rsp_resp   (rsp_resp),
        .m_axi_lite (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural slave ----------------
    data_t slave_mem [BUFFER_SIZE] = '{default: '0};
    addr_t s_awaddr;
    logic  stall_w = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.awready <= 1'b0;
            bus.wready  <= 1'b0;
            bus.bvalid  <= 1'b0;
            bus.bresp   <= RESP_OKAY;
            bus.arready <= 1'b0;
            bus.rvalid  <= 1'b0;
            bus.rdata   <= '0;
            bus.rresp   <= RESP_OKAY;
            s_awaddr    <= '0;
        end else begin
            bus.awready <= 1'($urandom_range(0, 1));
            bus.wready  <= stall_w ? 1'b0 : 1'($urandom_range(0, 1));
            bus.arready <= 1'($urandom_range(0, 1));
            if (bus.awvalid && bus.awready)
                s_awaddr <= bus.awaddr;
            if (bus.wvalid && bus.wready) begin
                slave_mem[int'(s_awaddr) % BUFFER_SIZE] <= bus.wdata;
                bus.bvalid <= 1'b1;
                bus.bresp  <= RESP_OKAY;
            end else if (bus.bvalid && bus.bready) begin
                bus.bvalid <= 1'b0;
            end
            if (bus.arvalid && bus.arready) begin
                bus.rvalid <= 1'b1;
                bus.rdata  <= slave_mem[int'(bus.araddr) % BUFFER_SIZE];
                bus.rresp  <= RESP_OKAY;
            end else if (bus.rvalid && bus.rready) begin
                bus.rvalid <= 1'b0;
                bus.rdata  <= '0;
            end
        end
    end

    // ---------------- protocol monitor ----------------
    logic  e_rst = 1'b0;
    logic  e_arv = 1'b0, e_arr = 1'b0;
    logic  e_awv = 1'b0, e_awr = 1'b0;
    logic  e_wv = 1'b0, e_wr = 1'b0;
    logic  e_rspv = 1'b0, e_rspr = 1'b0;
    addr_t e_ara = '0, e_awa = '0;
    data_t e_wd = '0;
    strb_t e_ws = '0;
    logic  e_rw = 1'b0;
    data_t e_rd = '0;
    resp_t e_rr = '0;
    int    ar_hs = 0, aw_hs = 0, w_hs = 0;
    int    ar_rises = 0, aw_rises = 0;

    // Snapshot of every signal as seen by the clock edge.
    always @(posedge clk) begin
        e_rst  <= rst_n;
        e_arv  <= bus.arvalid;
        e_arr  <= bus.arready;
        e_ara  <= bus.araddr;
        e_awv  <= bus.awvalid;
        e_awr  <= bus.awready;
        e_awa  <= bus.awaddr;
        e_wv   <= bus.wvalid;
        e_wr   <= bus.wready;
        e_wd   <= bus.wdata;
        e_ws   <= bus.wstrb;
        e_rspv <= rsp_valid;
        e_rspr <= rsp_ready;
        e_rw   <= rsp_write;
        e_rd   <= rsp_rdata;
        e_rr   <= rsp_resp;
        if (rst_n && bus.arvalid && bus.arready) ar_hs <= ar_hs + 1;
        if (rst_n && bus.awvalid && bus.awready) aw_hs <= aw_hs + 1;
        if (rst_n && bus.wvalid && bus.wready)   w_hs  <= w_hs + 1;
    end

    // Valid/payload hold rules and zeroed idle payloads, checked mid-cycle.
    always @(negedge clk) begin
        if (rst_n && e_rst) begin
            if (e_arv && !e_arr)
                chk("ar_hold", 128'({bus.arvalid, bus.araddr}),
                    128'({1'b1, e_ara}));
            if (e_awv && !e_awr)
                chk("aw_hold", 128'({bus.awvalid, bus.awaddr}),
                    128'({1'b1, e_awa}));
            if (e_wv && !e_wr)
                chk("w_hold", 128'({bus.wvalid, bus.wstrb, bus.wdata}),
                    128'({1'b1, e_ws, e_wd}));
            if (e_rspv && !e_rspr)
                chk("rsp_hold",
                    128'({rsp_valid, rsp_write, rsp_resp, rsp_rdata}),
                    128'({1'b1, e_rw, e_rr, e_rd}));
            chk("bus_idle_zero",
                128'({bus.arvalid ? 8'h0 : bus.araddr,
                      bus.awvalid ? 8'h0 : bus.awaddr,
                      bus.wvalid ? 36'h0 : {bus.wstrb, bus.wdata}}),
                128'(0));
            if (bus.arvalid && !e_arv) ar_rises++;
            if (bus.awvalid && !e_awv) aw_rises++;
        end
    end

    // ---------------- reference model ----------------
    data_t ref_mem [BUFFER_SIZE] = '{default: '0};

    function automatic logic [127:0] all_outputs();
        return 128'({cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp,
                     bus.arvalid, bus.araddr, bus.rready,
                     bus.awvalid, bus.awaddr, bus.wvalid, bus.wdata,
                     bus.wstrb, bus.bready});
    endfunction

    task automatic send_cmd(input logic w, input addr_t a, input data_t d);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", 128'(n < 100), 128'(1));
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
    endtask

    task automatic get_rsp(input int hold, output logic w, output data_t rd,
                           output resp_t rs);
        int n;
        n = 0;
        while (!rsp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_timeout", 128'(n < 200), 128'(1));
        w  = rsp_write;
        rd = rsp_rdata;
        rs = rsp_resp;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("rsp_stalled",
                128'({rsp_valid, rsp_write, rsp_rdata, rsp_resp}),
                128'({1'b1, w, rd, rs}));
            chk("stall_quiet",
                128'({cmd_ready, bus.arvalid, bus.awvalid, bus.wvalid}),
                128'(0));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic run_and_check(input string tag, input logic w,
                                 input addr_t a, input data_t d,
                                 input int hold);
        logic  gw;
        data_t grd;
        resp_t grs;
        data_t exp_rd;
        resp_t exp_rs;
        if (int'(a) >= BUFFER_SIZE) begin
            exp_rs = RESP_SLVERR;
            exp_rd = '0;
        end else if (w) begin
            exp_rs = RESP_OKAY;
            exp_rd = '0;
            ref_mem[int'(a)] = d;
        end else begin
            exp_rs = RESP_OKAY;
            exp_rd = ref_mem[int'(a)];
        end
        send_cmd(w, a, d);
        get_rsp(hold, gw, grd, grs);
        chk({tag, "_write"}, 128'(gw), 128'(w));
        chk({tag, "_rdata"}, 128'(grd), 128'(exp_rd));
        chk({tag, "_resp"}, 128'(grs), 128'(exp_rs));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int    h_ar, h_aw, h_w, r_ar, r_aw, n;
        logic  gw;
        data_t grd;
        resp_t grs;

        // reset state
        repeat (2) @(negedge clk);
        chk("reset_outputs", all_outputs(), 128'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", 128'(cmd_ready), 128'(1));

        // 1: single write
        h_ar = ar_hs;
        h_aw = aw_hs;
        h_w  = w_hs;
        run_and_check("wr5", 1'b1, 8'd5, 32'hDEADBEEF, 0);
        chk("wr5_aw_hs", 128'(aw_hs - h_aw), 128'(1));
        chk("wr5_w_hs", 128'(w_hs - h_w), 128'(1));
        chk("wr5_ar_hs", 128'(ar_hs - h_ar), 128'(0));

        // 2: read it back
        send_cmd(1'b0, 8'd5, '0);
        get_rsp(0, gw, grd, grs);
        chk("rd5_rdata", 128'(grd), 128'(32'hDEADBEEF));
        chk("rd5_resp", 128'(grs), 128'(RESP_OKAY));
        chk("rd5_write", 128'(gw), 128'(0));

        // 3: response held off for 10 cycles
        run_and_check("hold", 1'b0, 8'd5, '0, 10);
        chk("hold_release", 128'({rsp_valid, cmd_ready}), 128'(2'b01));

        // 4: out-of-range commands stay off the bus
        r_ar = ar_rises;
        r_aw = aw_rises;
        run_and_check("rej_rd", 1'b0, addr_t'(BUFFER_SIZE), '0, 0);
        run_and_check("rej_wr", 1'b1, addr_t'(BUFFER_SIZE), 32'h1234, 2);
        chk("rej_no_ar", 128'(ar_rises - r_ar), 128'(0));
        chk("rej_no_aw", 128'(aw_rises - r_aw), 128'(0));

        // 5: asynchronous reset while in the W phase
        stall_w = 1'b1;
        send_cmd(1'b1, 8'd0, 32'hA5A55A5A);
        n = 0;
        while (!bus.wvalid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reach_w", 128'(bus.wvalid), 128'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", all_outputs(), 128'(0));
        @(negedge clk);
        chk("reset_held", all_outputs(), 128'(0));
        stall_w = 1'b0;
        rst_n = 1'b1;
        send_cmd(1'b0, 8'd0, '0);
        get_rsp(0, gw, grd, grs);
        chk("post_reset_rdata", 128'(grd), 128'(0));
        chk("post_reset_resp", 128'(grs), 128'(RESP_OKAY));

        // 6: random commands against the memory model
        for (int i = 0; i < 100; i++) begin
            logic  w;
            addr_t a;
            data_t d;
            w = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0)
                a = addr_t'(BUFFER_SIZE + $urandom_range(0, 200));
            else
                a = addr_t'($urandom_range(0, BUFFER_SIZE - 1));
            d = $urandom;
            run_and_check("rnd", w, a, d, int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
